// File: rtl/hangman_word_engine.sv
// hangman_word_engine: secret-word store and sequential guess matcher.
// A word is loaded one character at a time. Each new guess is then compared
// against one stored position per clock, and the engine keeps a reveal mask,
// the set of letters already guessed, a miss counter and the win/lose flags.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_LOAD   | appending characters; word_done with a non-empty word leaves
//   S_READY  | idle, guess_ready high, waiting for a guess
//   S_SCAN   | comparing the latched guess against mem[idx], one per clock
//   S_RESULT | one-cycle result pulse; misses/remaining/won/lost update here
//   S_OVER   | game finished; only new_game or reset leave
module hangman_word_engine #(
    parameter int CHAR_W     = 5,
    parameter int MAX_LEN    = 16,
    parameter int LEN_W      = 5,
    parameter int MAX_MISSES = 6,
    parameter int MISS_W     = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              new_game,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              word_done,
    input  logic              guess_valid,
    input  logic [CHAR_W-1:0] guess_in,
    output logic              guess_ready,
    output logic              result_valid,
    output logic [LEN_W-1:0]  hit_count,
    output logic              repeat_guess,
    output logic [MISS_W-1:0] misses,
    output logic [LEN_W-1:0]  remaining,
    output logic [LEN_W-1:0]  word_len,
    output logic              load_ovf,
    output logic              game_over,
    output logic              won,
    output logic              lost,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [CHAR_W-1:0] rd_char,
    output logic              rd_revealed
);

    localparam int ALPHA = 2 ** CHAR_W;

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_SCAN,
        S_RESULT,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [CHAR_W-1:0]  mem_q [MAX_LEN];
    logic [CHAR_W-1:0]  mem_d [MAX_LEN];
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [ALPHA-1:0]   guessed_q, guessed_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   acc_q, acc_d;
    logic [CHAR_W-1:0]  guess_q, guess_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   hit_q, hit_d;
    logic               rep_q, rep_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               won_q, won_d;
    logic               lost_q, lost_d;

    logic [CHAR_W-1:0]  cur_char;
    logic [LEN_W-1:0]   pop_cnt;
    logic [LEN_W-1:0]   len_tmp;
    logic [LEN_W-1:0]   acc_nxt;
    logic [LEN_W-1:0]   rem_nxt;
    logic [MISS_W-1:0]  miss_nxt;
    logic               match;

    // Character under the scan pointer and count of revealed positions.
    always_comb begin
        cur_char = '0;
        pop_cnt  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == idx_q) cur_char = mem_q[i];
            pop_cnt = pop_cnt + LEN_W'(mask_q[i]);
        end
    end

    // Next-state logic; new_game overrides every state.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        len_d     = len_q;
        mask_d    = mask_q;
        guessed_d = guessed_q;
        misses_d  = misses_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        guess_d   = guess_q;
        ovf_d     = ovf_q;
        hit_d     = hit_q;
        rep_d     = rep_q;
        rem_d     = rem_q;
        won_d     = won_q;
        lost_d    = lost_q;
        len_tmp   = len_q;
        acc_nxt   = acc_q;
        rem_nxt   = rem_q;
        miss_nxt  = misses_q;
        match     = 1'b0;

        if (new_game) begin
            state_d   = S_LOAD;
            len_d     = '0;
            mask_d    = '0;
            guessed_d = '0;
            misses_d  = '0;
            idx_d     = '0;
            acc_d     = '0;
            guess_d   = '0;
            ovf_d     = 1'b0;
            hit_d     = '0;
            rep_d     = 1'b0;
            rem_d     = '0;
            won_d     = 1'b0;
            lost_d    = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (char_valid) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (LEN_W'(i) == len_q) mem_d[i] = char_in;
                            end
                            len_tmp = len_q + LEN_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    len_d = len_tmp;
                    // The length seen by word_done already includes a same-cycle char.
                    if (word_done && (len_tmp != '0)) begin
                        rem_d   = len_tmp;
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (guess_valid) begin
                        guess_d = guess_in;
                        if (guessed_q[guess_in]) begin
                            rep_d   = 1'b1;
                            hit_d   = '0;
                            state_d = S_RESULT;
                        end else begin
                            guessed_d[guess_in] = 1'b1;
                            acc_d   = '0;
                            idx_d   = '0;
                            state_d = S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    match   = (cur_char == guess_q);
                    acc_nxt = acc_q + LEN_W'(match);
                    acc_d   = acc_nxt;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (match && (LEN_W'(i) == idx_q)) mask_d[i] = 1'b1;
                    end
                    // Positions at or above word_len are never visited.
                    if (idx_q == len_q - LEN_W'(1)) begin
                        hit_d   = acc_nxt;
                        rep_d   = 1'b0;
                        state_d = S_RESULT;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
                S_RESULT: begin
                    if (!rep_q && (hit_q == '0) && (misses_q < MISS_W'(MAX_MISSES))) begin
                        miss_nxt = misses_q + MISS_W'(1);
                    end
                    misses_d = miss_nxt;
                    rem_nxt  = len_q - pop_cnt;
                    rem_d    = rem_nxt;
                    if (rem_nxt == '0) begin
                        won_d   = 1'b1;
                        state_d = S_OVER;
                    end else if (miss_nxt == MISS_W'(MAX_MISSES)) begin
                        lost_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_LOAD;
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            guessed_q <= '0;
            misses_q  <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            guess_q   <= '0;
            ovf_q     <= 1'b0;
            hit_q     <= '0;
            rep_q     <= 1'b0;
            rem_q     <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            guessed_q <= guessed_d;
            misses_q  <= misses_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            guess_q   <= guess_d;
            ovf_q     <= ovf_d;
            hit_q     <= hit_d;
            rep_q     <= rep_d;
            rem_q     <= rem_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
        end
    end

    // Display read port: only revealed positions inside the word are visible.
    always_comb begin
        rd_char     = '0;
        rd_revealed = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) == rd_addr) && (LEN_W'(i) < len_q) && mask_q[i]) begin
                rd_revealed = 1'b1;
                rd_char     = mem_q[i];
            end
        end
    end

    assign guess_ready  = (state_q == S_READY);
    assign result_valid = (state_q == S_RESULT);
    assign game_over    = (state_q == S_OVER);
    assign hit_count    = hit_q;
    assign repeat_guess = rep_q;
    assign misses       = misses_q;
    assign remaining    = rem_q;
    assign word_len     = len_q;
    assign load_ovf     = ovf_q;
    assign won          = won_q;
    assign lost         = lost_q;

endmodule
